tile_config_responder: RTL and testbench

Per-tile endpoint of the CGRA configuration bus. It decodes the global 32-bit `config_addr_in`/`config_data_in` stream that the top-level loader drives once per cycle, and captures writes aimed at this tile/feature into shadow registers. A commit command atomically transfers the shadow registers to the active registers, and registered readback lets the loader or test bench verify the contents. One instance sits beside each tile feature (PE core, SB, CB, IO pad block).

---
 rtl/cfg_bus_pkg.sv | 24 ++
 rtl/tile_config_responder_if.sv | 19 +
 rtl/cfg_addr_decode.sv | 51 +++++
 rtl/tile_config_responder.sv | 109 ++++++++++
 tb/tb_tile_config_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the CGRA configuration bus: address field slices,
// broadcast tile id, default commit index and the decoded-access record.
package cfg_bus_pkg;

    localparam int CFG_TILE_LSB = 0;
    localparam int CFG_TILE_MSB = 15;
    localparam int CFG_FEAT_LSB = 16;
    localparam int CFG_FEAT_MSB = 23;
    localparam int CFG_REG_LSB  = 24;
    localparam int CFG_REG_MSB  = 31;

    localparam logic [15:0] CFG_BROADCAST_TILE     = 16'hFFFF;
    localparam logic [7:0]  CFG_COMMIT_REG_DEFAULT = 8'hFF;

    // write/read are already qualified by the match rules; hit is their OR
    typedef struct packed {
        logic        write;
        logic        read;
        logic        hit;
        logic [7:0]  idx;
        logic [31:0] data;
    } cfg_access_t;

endpackage

// File: rtl/tile_config_responder_if.sv
// Loader-facing configuration bus: address/data/strobes in, readback out.
interface tile_config_responder_if;
    logic [31:0] config_addr_in;
    logic [31:0] config_data_in;
    logic        config_write_in;
    logic        config_read_in;
    logic [31:0] read_data_out;
    logic        read_valid_out;

    modport master (
        output config_addr_in, config_data_in, config_write_in, config_read_in,
        input  read_data_out, read_valid_out
    );

    modport slave (
        input  config_addr_in, config_data_in, config_write_in, config_read_in,
        output read_data_out, read_valid_out
    );
endinterface

// File: rtl/cfg_addr_decode.sv
// Address match for one tile/feature plus the stage-1 access register.
module cfg_addr_decode
    import cfg_bus_pkg::*;
#(
    parameter logic [15:0] TILE_ID    = 16'h0000,
    parameter logic [7:0]  FEATURE_ID = 8'h00
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] config_addr_in,
    input  logic [31:0] config_data_in,
    input  logic        config_write_in,
    input  logic        config_read_in,
    output cfg_access_t decoded
);

    logic [15:0] tile;
    logic [7:0]  feat;
    logic        feat_match;
    logic        write_hit;
    logic        read_hit;
    cfg_access_t access_next;
    cfg_access_t access_reg;

    // Broadcast tile id is accepted for writes only; reads must name the tile.
    always_comb begin
        tile        = config_addr_in[CFG_TILE_MSB:CFG_TILE_LSB];
        feat        = config_addr_in[CFG_FEAT_MSB:CFG_FEAT_LSB];
        feat_match  = (feat == FEATURE_ID);
        write_hit   = config_write_in && feat_match &&
                      ((tile == TILE_ID) || (tile == CFG_BROADCAST_TILE));
        read_hit    = config_read_in && feat_match && (tile == TILE_ID);
        access_next = '0;
        access_next.write = write_hit;
        access_next.read  = read_hit;
        access_next.hit   = write_hit || read_hit;
        access_next.idx   = config_addr_in[CFG_REG_MSB:CFG_REG_LSB];
        access_next.data  = config_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            access_reg <= '0;
        end else begin
            access_reg <= access_next;
        end
    end

    assign decoded = access_reg;

endmodule

// File: rtl/tile_config_responder.sv
// Per-tile configuration endpoint: shadow registers, atomic commit to the
// active set, sticky error flag, saturating write counter and readback.
module tile_config_responder
    import cfg_bus_pkg::*;
#(
    parameter logic [15:0] TILE_ID    = 16'h0000,
    parameter logic [7:0]  FEATURE_ID = 8'h00,
    parameter int          NUM_REGS   = 4,
    parameter logic [7:0]  COMMIT_REG = CFG_COMMIT_REG_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    tile_config_responder_if.slave   bus,
    output logic [NUM_REGS*32-1:0]   cfg_out,
    output logic                     cfg_commit_out,
    output logic                     err_out,
    output logic [15:0]              write_count_out
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    cfg_access_t      dec;
    logic [IDX_W-1:0] slot;
    logic             idx_valid;
    logic             idx_commit;

    logic [31:0] shadow_reg [NUM_REGS];
    logic [31:0] active_reg [NUM_REGS];
    logic        commit_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [15:0] count_reg;

    cfg_addr_decode #(
        .TILE_ID    (TILE_ID),
        .FEATURE_ID (FEATURE_ID)
    ) u_decode (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .config_addr_in  (bus.config_addr_in),
        .config_data_in  (bus.config_data_in),
        .config_write_in (bus.config_write_in),
        .config_read_in  (bus.config_read_in),
        .decoded         (dec)
    );

    always_comb begin
        slot       = dec.idx[IDX_W-1:0];
        idx_valid  = (int'(dec.idx) < NUM_REGS);
        idx_commit = (dec.idx == COMMIT_REG);
    end

    // Readback samples active/count before this cycle's write lands, which
    // gives read-before-write when both strobes hit together.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            commit_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
            count_reg  <= '0;
        end else begin
            commit_reg <= 1'b0;
            rvalid_reg <= dec.read;
            if (dec.read) begin
                if (idx_valid) begin
                    rdata_reg <= active_reg[slot];
                end else if (idx_commit) begin
                    rdata_reg <= {16'h0000, count_reg};
                end else begin
                    rdata_reg <= 32'h0;
                end
            end
            if (dec.write && idx_valid) begin
                shadow_reg[slot] <= dec.data;
                if (count_reg != 16'hFFFF) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
            // Commit copies the old shadow values, so a same-cycle shadow
            // write is left for the following commit.
            if (dec.write && idx_commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    active_reg[i] <= shadow_reg[i];
                end
                commit_reg <= 1'b1;
            end
            if (dec.hit && !idx_valid && !idx_commit) begin
                err_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg_out
        assign cfg_out[gi*32 +: 32] = active_reg[gi];
    end

    assign cfg_commit_out     = commit_reg;
    assign err_out            = err_reg;
    assign write_count_out    = count_reg;
    assign bus.read_data_out  = rdata_reg;
    assign bus.read_valid_out = rvalid_reg;

endmodule

// File: tb/tb_tile_config_responder.sv
// Self-checking bench: directed test-plan sequence, randomized traffic and
// counter saturation, checked every cycle against a behavioural model.
module tb_tile_config_responder;

    localparam logic [15:0] T_ID   = 16'h0012;
    localparam logic [7:0]  F_ID   = 8'h03;
    localparam int          NREG   = 4;
    localparam logic [7:0]  C_REG  = 8'hFF;
    localparam logic [15:0] BCAST  = 16'hFFFF;

    logic clk = 1'b0;
    logic reset_in = 1'b1;
    logic [NREG*32-1:0] cfg_out;
    logic cfg_commit_out;
    logic err_out;
    logic [15:0] write_count_out;

    tile_config_responder_if bus ();

    tile_config_responder #(
        .TILE_ID    (T_ID),
        .FEATURE_ID (F_ID),
        .NUM_REGS   (NREG),
        .COMMIT_REG (C_REG)
    ) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .bus             (bus),
        .cfg_out         (cfg_out),
        .cfg_commit_out  (cfg_commit_out),
        .err_out         (err_out),
        .write_count_out (write_count_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen at each rising edge
    logic        smp_rst, smp_w, smp_r;
    logic [31:0] smp_addr, smp_data;
    always @(posedge clk) begin
        smp_rst  <= reset_in;
        smp_w    <= bus.config_write_in;
        smp_r    <= bus.config_read_in;
        smp_addr <= bus.config_addr_in;
        smp_data <= bus.config_data_in;
    end

    // Behavioural model state
    logic [31:0] m_shadow [NREG];
    logic [31:0] m_active [NREG];
    logic [15:0] m_count  = '0;
    logic        m_err    = 1'b0;
    logic        m_commit = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = '0;
    bit          p_valid  = 1'b0;
    logic        p_w, p_r;
    logic [31:0] p_addr, p_data;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_count = '0; m_err = 1'b0; m_commit = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; p_valid = 1'b0;
    endtask

    task automatic model_apply(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [15:0] tile;
        logic [7:0]  feat, idx;
        bit          whit, rhit;
        tile = a[15:0]; feat = a[23:16]; idx = a[31:24];
        whit = w && feat == F_ID && (tile == T_ID || tile == BCAST);
        rhit = r && feat == F_ID && tile == T_ID;
        if (rhit) begin
            m_rvalid = 1'b1;
            if (idx < NREG)        m_rdata = m_active[idx];
            else if (idx == C_REG) m_rdata = {16'h0, m_count};
            else                   m_rdata = 32'h0;
        end
        if (whit) begin
            if (idx < NREG) begin
                m_shadow[idx] = d;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end else if (idx == C_REG) begin
                for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
                m_commit = 1'b1;
            end
        end
        if ((whit || rhit) && idx >= NREG && idx != C_REG) m_err = 1'b1;
    endtask

    // Model step and per-cycle comparison, half a clock after each edge
    initial begin
        logic [127:0] exp_cfg;
        model_reset();
        forever begin
            @(negedge clk);
            if (smp_rst === 1'b1) begin
                model_reset();
            end else begin
                m_commit = 1'b0;
                m_rvalid = 1'b0;
                if (p_valid) model_apply(p_w, p_r, p_addr, p_data);
                p_valid = 1'b1;
                p_w = smp_w; p_r = smp_r; p_addr = smp_addr; p_data = smp_data;
            end
            if (!done) begin
                for (int i = 0; i < NREG; i++) exp_cfg[i*32 +: 32] = m_active[i];
                chk("cfg_out", cfg_out, exp_cfg);
                chk("cfg_commit_out", cfg_commit_out, m_commit);
                chk("read_valid_out", bus.read_valid_out, m_rvalid);
                chk("read_data_out", bus.read_data_out, m_rdata);
                chk("err_out", err_out, m_err);
                chk("write_count_out", write_count_out, m_count);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [15:0] tile, input logic [7:0] feat, input logic [7:0] idx);
        return {idx, feat, tile};
    endfunction

    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        bus.config_write_in = w;
        bus.config_read_in  = r;
        bus.config_addr_in  = a;
        bus.config_data_in  = d;
        $display("txn w=%0b r=%0b addr=%h data=%h rst=%0b", w, r, a, d, reset_in);
        @(negedge clk); #1;
    endtask

    task automatic idle();
        bus.config_write_in = 1'b0;
        bus.config_read_in  = 1'b0;
        bus.config_addr_in  = '0;
        bus.config_data_in  = '0;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [15:0] tile;
        logic [7:0]  feat, idx;
        bus.config_write_in = 1'b0;
        bus.config_read_in  = 1'b0;
        bus.config_addr_in  = '0;
        bus.config_data_in  = '0;
        reset_in = 1'b1;
        repeat (3) idle();
        reset_in = 1'b0;
        idle();
        chk("reset cfg_out", cfg_out, 128'h0);
        chk("reset count", write_count_out, 16'h0);
        chk("reset valid", bus.read_valid_out, 1'b0);

        issue(1, 0, mk(T_ID, F_ID, 8'd2), 32'hA5A5_0002);
        idle();
        chk("write count 1", write_count_out, 16'd1);
        chk("uncommitted cfg_out", cfg_out, 128'h0);

        issue(0, 1, mk(T_ID, F_ID, 8'd2), 32'h0);
        idle();
        chk("read before commit valid", bus.read_valid_out, 1'b1);
        chk("read before commit data", bus.read_data_out, 32'h0);

        issue(1, 0, mk(T_ID, F_ID, C_REG), 32'hDEAD_BEEF);
        chk("commit +1 no pulse", cfg_commit_out, 1'b0);
        idle();
        chk("commit +2 pulse", cfg_commit_out, 1'b1);
        chk("commit reg2", cfg_out[95:64], 32'hA5A5_0002);
        idle();
        chk("commit +3 no pulse", cfg_commit_out, 1'b0);

        issue(0, 1, mk(T_ID, F_ID, 8'd2), 32'h0);
        idle();
        chk("read after commit", bus.read_data_out, 32'hA5A5_0002);
        issue(0, 1, mk(T_ID, F_ID, C_REG), 32'h0);
        idle();
        chk("read commit reg", bus.read_data_out, 32'h0000_0001);

        issue(1, 0, mk(BCAST, F_ID, 8'd0), 32'h0000_1234);
        issue(1, 0, mk(BCAST, F_ID, C_REG), 32'h0);
        idle();
        chk("broadcast reg0", cfg_out[31:0], 32'h0000_1234);
        issue(0, 1, mk(BCAST, F_ID, 8'd0), 32'h0);
        idle();
        chk("broadcast read no valid", bus.read_valid_out, 1'b0);

        issue(1, 0, mk(T_ID, F_ID + 8'd1, 8'd1), 32'hFFFF_FFFF);
        idle();
        chk("wrong feature count", write_count_out, 16'd2);
        chk("wrong feature no err", err_out, 1'b0);

        issue(1, 0, mk(T_ID, F_ID, 8'd4), 32'h5555_5555);
        chk("err +1 low", err_out, 1'b0);
        idle();
        chk("err +2 high", err_out, 1'b1);
        idle();
        chk("err sticky", err_out, 1'b1);
        chk("err count unchanged", write_count_out, 16'd2);

        issue(1, 0, mk(T_ID, F_ID, 8'd0), 32'h0000_0001);
        issue(1, 0, mk(T_ID, F_ID, C_REG), 32'h0);
        idle();
        chk("b2b commit reg0", cfg_out[31:0], 32'h0000_0001);
        issue(1, 1, mk(T_ID, F_ID, 8'd0), 32'h0000_0077);
        idle();
        chk("rw old value", bus.read_data_out, 32'h0000_0001);
        chk("rw count", write_count_out, 16'd4);

        issue(1, 0, mk(T_ID, F_ID, 8'd3), 32'hDEAD_0003);
        reset_in = 1'b1;
        idle();
        reset_in = 1'b0;
        idle();
        idle();
        chk("reset drops inflight count", write_count_out, 16'd0);
        chk("reset clears err", err_out, 1'b0);
        chk("reset clears cfg", cfg_out, 128'h0);

        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    tile = T_ID;
                2:       tile = BCAST;
                default: tile = 16'($urandom);
            endcase
            feat = ($urandom_range(0, 4) == 0) ? 8'($urandom) : F_ID;
            case ($urandom_range(0, 5))
                0, 1, 2: idx = 8'($urandom_range(0, NREG - 1));
                3:       idx = C_REG;
                4:       idx = 8'($urandom_range(NREG, NREG + 1));
                default: idx = 8'($urandom);
            endcase
            reset_in = ($urandom_range(0, 199) == 0);
            issue(1'($urandom), 1'($urandom), mk(tile, feat, idx), $urandom);
        end
        reset_in = 1'b0;
        idle();

        for (int n = 0; n < 65540; n++) begin
            bus.config_write_in = 1'b1;
            bus.config_read_in  = 1'b0;
            bus.config_addr_in  = mk(T_ID, F_ID, 8'(n % NREG));
            bus.config_data_in  = $urandom;
            @(negedge clk); #1;
        end
        $display("txn saturation burst of 65540 writes done");
        idle();
        idle();
        chk("count saturated", write_count_out, 16'hFFFF);
        issue(0, 1, mk(T_ID, F_ID, C_REG), 32'h0);
        idle();
        chk("read saturated count", bus.read_data_out, 32'h0000_FFFF);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
